// File: rtl/glm_pkg.sv
// rtl/glm_pkg.sv - shared model encodings, Q16.16 constants and saturation helper for glm_modify
package glm_pkg;

    typedef enum logic [1:0] {
        LINREG = 2'd0,
        LOGREG = 2'd1,
        SVM    = 2'd2
    } t_glm_model;

    localparam logic signed [31:0] ONE  = 32'sh0001_0000;
    localparam logic signed [31:0] HALF = 32'sh0000_8000;

    function automatic logic [31:0] sat32(input logic signed [63:0] x);
        if (x > 64'sh0000_0000_7FFF_FFFF)
            return 32'h7FFF_FFFF;
        else if (x < 64'shFFFF_FFFF_8000_0000)
            return 32'h8000_0000;
        else
            return x[31:0];
    endfunction

endpackage

// File: rtl/glm_modify_pipe.sv
// rtl/glm_modify_pipe.sv - three-stage error / scale / shift pipeline with a shared stall enable
module glm_modify_pipe
    import glm_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] dot,
    input  logic [31:0] label,
    input  logic [31:0] step,
    input  logic [1:0]  model,
    output logic        out_valid,
    output logic [31:0] out_data
);

    function automatic logic signed [63:0] sx(input logic [31:0] v);
        return $signed({{32{v[31]}}, v});
    endfunction

    logic signed [31:0] dot_s;
    logic signed [31:0] label_s;
    logic signed [31:0] sig_raw;
    logic signed [31:0] sig;
    logic signed [63:0] e_wide;
    logic               violated;

    logic               s1_valid;
    logic        [31:0] s1_e;
    logic               s2_valid;
    logic signed [63:0] s2_p;

    assign dot_s   = $signed(dot);
    assign label_s = $signed(label);

    always_comb begin
        // Hard sigmoid: 0.25*dot + 0.5, clamped into [0, 1.0]
        sig_raw = (dot_s >>> 2) + HALF;
        sig     = sig_raw;
        if (sig_raw < 0)
            sig = '0;
        else if (sig_raw > ONE)
            sig = ONE;

        violated = (label_s > 0) ? (dot_s < ONE) : (dot_s > -ONE);

        case (model)
            LOGREG:  e_wide = sx(sig) - sx(label);
            SVM:     e_wide = violated ? -sx(label) : 64'sd0;
            default: e_wide = sx(dot) - sx(label);
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_e      <= '0;
            s2_valid  <= 1'b0;
            s2_p      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_e      <= sat32(e_wide);
            s2_valid  <= s1_valid;
            s2_p      <= sx(s1_e) * sx(step);
            out_valid <= s2_valid;
            out_data  <= sat32(s2_p >>> FRAC_BITS);
        end
    end

endmodule

// File: rtl/glm_modify.sv
// rtl/glm_modify.sv - pairs dot results with labels and emits step-scaled gradient scalars
module glm_modify
    import glm_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_start,
    output logic             op_done,
    input  logic [3:0][31:0] regs,
    input  logic             dot_valid,
    input  logic [31:0]      dot_data,
    output logic             dot_ready,
    input  logic             label_valid,
    input  logic [31:0]      label_data,
    output logic             label_ready,
    output logic             grad_valid,
    output logic [31:0]      grad_data,
    input  logic             grad_ready
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PROCESS = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]  state;
    logic [15:0] num;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
    logic [31:0] step;
    logic [1:0]  model;
    logic        pipe_en;
    logic        accept;
    logic        unused_bits;

    assign unused_bits = ^{regs[0][31:16], regs[2][31:2], regs[3]};

    // A held output freezes every stage so nothing in flight is overwritten
    assign pipe_en     = !(grad_valid && !grad_ready);
    assign accept      = (state == S_PROCESS) && (in_cnt < num) && dot_valid && label_valid && pipe_en;
    assign dot_ready   = accept;
    assign label_ready = accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            num     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            step    <= '0;
            model   <= '0;
            op_done <= 1'b0;
        end else begin
            op_done <= 1'b0;
            if (accept)
                in_cnt <= in_cnt + 16'd1;
            if (grad_valid && grad_ready)
                out_cnt <= out_cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (op_start) begin
                        num     <= regs[0][15:0];
                        step    <= regs[1];
                        model   <= regs[2][1:0];
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        if (regs[0][15:0] == 16'd0)
                            op_done <= 1'b1;
                        else
                            state <= S_PROCESS;
                    end
                end
                S_PROCESS: begin
                    if (in_cnt == num)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_cnt == num) begin
                        op_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    glm_modify_pipe #(
        .FRAC_BITS (FRAC_BITS)
    ) u_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .en        (pipe_en),
        .in_valid  (accept),
        .dot       (dot_data),
        .label     (label_data),
        .step      (step),
        .model     (model),
        .out_valid (grad_valid),
        .out_data  (grad_data)
    );

endmodule

// File: tb/tb_glm_modify.sv
// tb/tb_glm_modify.sv - directed self-checking bench for glm_modify
module tb_glm_modify;

    logic             clk;
    logic             resetn;
    logic             op_start;
    logic             op_done;
    logic [3:0][31:0] regs;
    logic             dot_valid;
    logic [31:0]      dot_data;
    logic             dot_ready;
    logic             label_valid;
    logic [31:0]      label_data;
    logic             label_ready;
    logic             grad_valid;
    logic [31:0]      grad_data;
    logic             grad_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] bp_dot [8] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_1234,
                                32'hFFFF_0000, 32'h0010_0000, 32'h0000_0000, 32'h7FFF_0000};
    logic [31:0] bp_lab [8] = '{32'h0000_0000, 32'h0000_8000, 32'h0005_0000, 32'h0000_0234,
                                32'h0001_0000, 32'h000F_0000, 32'h0000_0000, 32'h7FFE_0000};
    logic [31:0] bp_exp [8] = '{32'h0001_0000, 32'h0001_8000, 32'hFFFE_0000, 32'h0000_1000,
                                32'hFFFE_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000};

    glm_modify #(.FRAC_BITS(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .op_start    (op_start),
        .op_done     (op_done),
        .regs        (regs),
        .dot_valid   (dot_valid),
        .dot_data    (dot_data),
        .dot_ready   (dot_ready),
        .label_valid (label_valid),
        .label_data  (label_data),
        .label_ready (label_ready),
        .grad_valid  (grad_valid),
        .grad_data   (grad_data),
        .grad_ready  (grad_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] n, input logic [31:0] st, input logic [1:0] m);
        regs[0] = {16'd0, n};
        regs[1] = st;
        regs[2] = {30'd0, m};
        regs[3] = 32'd0;
        @(negedge clk) op_start = 1'b1;
        @(negedge clk) op_start = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [1:0] m, input logic [31:0] st,
                              input logic [31:0] d, input logic [31:0] l, input logic [31:0] exp);
        int lat;
        bit seen;
        grad_ready = 1'b1;
        pulse_start(16'd1, st, m);
        dot_data    = d;
        label_data  = l;
        dot_valid   = 1'b1;
        label_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (dot_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, ":accept"}, {31'd0, seen}, 32'd1);
        check_eq({tag, ":label_ready"}, {31'd0, label_ready}, 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dot_valid   = 1'b0;
            label_valid = 1'b0;
            lat++;
            if (grad_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, ":latency"}, lat, 32'd3);
        check_eq({tag, ":grad"}, grad_data, exp);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (op_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, ":op_done"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_backpressure();
        int in_idx   = 0;
        int out_idx  = 0;
        int done_cnt = 0;
        int extra    = 0;
        int post     = 0;
        bit early    = 1'b0;
        bit held     = 1'b0;
        logic [31:0] hold_val = '0;
        grad_ready = 1'b1;
        pulse_start(16'd8, 32'h0001_0000, 2'd0);
        for (int c = 0; c < 200; c++) begin
            if (c != 0) @(negedge clk);
            if (held && grad_valid)
                check_eq("bp:hold_stable", grad_data, hold_val);
            if (in_idx < 8) begin
                dot_data    = bp_dot[in_idx];
                label_data  = bp_lab[in_idx];
                dot_valid   = 1'b1;
                label_valid = ((c % 3) != 2);
            end else begin
                dot_valid   = 1'b0;
                label_valid = 1'b0;
            end
            grad_ready = !(c >= 6 && c < 16);
            #1;
            if (op_done) begin
                done_cnt++;
                if (out_idx < 8) early = 1'b1;
            end
            if (dot_ready) in_idx++;
            held     = grad_valid && !grad_ready;
            hold_val = grad_data;
            if (grad_valid && grad_ready) begin
                if (out_idx < 8)
                    check_eq($sformatf("bp:out%0d", out_idx), grad_data, bp_exp[out_idx]);
                else
                    extra++;
                out_idx++;
            end
            if (out_idx >= 8) post++;
            if (post > 8) break;
        end
        dot_valid   = 1'b0;
        label_valid = 1'b0;
        grad_ready  = 1'b1;
        check_eq("bp:in_count", in_idx, 32'd8);
        check_eq("bp:out_count", out_idx, 32'd8);
        check_eq("bp:extra", extra, 32'd0);
        check_eq("bp:op_done_count", done_cnt, 32'd1);
        check_eq("bp:op_done_early", {31'd0, early}, 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        op_start    = 1'b0;
        regs        = '0;
        dot_valid   = 1'b0;
        dot_data    = '0;
        label_valid = 1'b0;
        label_data  = '0;
        grad_ready  = 1'b0;
        #1;
        check_eq("rst:op_done", {31'd0, op_done}, 32'd0);
        check_eq("rst:dot_ready", {31'd0, dot_ready}, 32'd0);
        check_eq("rst:label_ready", {31'd0, label_ready}, 32'd0);
        check_eq("rst:grad_valid", {31'd0, grad_valid}, 32'd0);
        check_eq("rst:grad_data", grad_data, 32'd0);
        @(negedge clk);
        @(negedge clk) resetn = 1'b1;

        run_single("lin", 2'd0, 32'h0000_8000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000);
        run_single("log0", 2'd1, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_8000);
        run_single("log1", 2'd1, 32'h0001_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h0001_0000);
        run_single("svm_v", 2'd2, 32'h0000_4000, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_C000);
        run_single("svm_ok", 2'd2, 32'h0000_4000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000);
        run_single("sat", 2'd0, 32'h0002_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_FFFF);
        run_single("m3", 2'd3, 32'h0000_8000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000);

        run_backpressure();

        // Zero-length instruction
        regs[0] = 32'd0;
        @(negedge clk) op_start = 1'b1;
        #1 check_eq("zero:dot_ready", {31'd0, dot_ready}, 32'd0);
        @(negedge clk) op_start = 1'b0;
        check_eq("zero:op_done", {31'd0, op_done}, 32'd1);
        check_eq("zero:dot_ready2", {31'd0, dot_ready}, 32'd0);
        @(negedge clk);
        check_eq("zero:op_done_off", {31'd0, op_done}, 32'd0);

        // Reset while the pipeline is full and the output is held
        grad_ready = 1'b0;
        pulse_start(16'd4, 32'h0001_0000, 2'd0);
        dot_data    = 32'h0002_0000;
        label_data  = 32'h0000_0000;
        dot_valid   = 1'b1;
        label_valid = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("mid:grad_valid_pre", {31'd0, grad_valid}, 32'd1);
        check_eq("mid:grad_data_pre", grad_data, 32'h0002_0000);
        #1 resetn = 1'b0;
        #1;
        check_eq("mid:grad_valid", {31'd0, grad_valid}, 32'd0);
        check_eq("mid:grad_data", grad_data, 32'd0);
        check_eq("mid:dot_ready", {31'd0, dot_ready}, 32'd0);
        check_eq("mid:label_ready", {31'd0, label_ready}, 32'd0);
        check_eq("mid:op_done", {31'd0, op_done}, 32'd0);
        dot_valid   = 1'b0;
        label_valid = 1'b0;
        grad_ready  = 1'b1;
        @(negedge clk) resetn = 1'b1;
        run_single("after_rst", 2'd0, 32'h0000_8000, 32'h0003_0000, 32'h0001_0000, 32'h0001_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
